// File: rtl/inst_mem_loadable_if.sv
// Loader and fetch handshake bundle for the loadable instruction memory.
// The master side is the loader/fetch unit, the slave side is the memory.
interface inst_mem_loadable_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst;
  logic                  inst_err;
  logic                  inst_ready;

  modport master (
    output load_en, load_addr, load_data, fetch_req, fetch_addr, inst_ready,
    input  load_ready, fetch_ready, inst_valid, inst, inst_err
  );

  modport slave (
    input  load_en, load_addr, load_data, fetch_req, fetch_addr, inst_ready,
    output load_ready, fetch_ready, inst_valid, inst, inst_err
  );
endinterface

// File: rtl/inst_mem_loadable.sv
// Loadable synchronous-read instruction memory. After reset every word is
// cleared to FILL (one word per cycle), then the loader port writes words and
// the fetch port returns one registered instruction per cycle with
// valid/ready backpressure. Addresses at or beyond DEPTH are flagged on fetch
// and dropped on load, never aliased.
module inst_mem_loadable #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 5,
  parameter int          DEPTH      = 20,
  parameter logic [31:0] FILL       = 32'h00000000
) (
  input  logic               clk,
  input  logic               resetn,
  inst_mem_loadable_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] FILL_W   = DATA_WIDTH'(FILL);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  vld_p1;
  logic                  err_p1;
  logic [DATA_WIDTH-1:0] inst_p1;

  logic                  load_ready;
  logic                  fetch_ready;
  logic                  load_acc;
  logic                  fetch_acc;
  logic                  load_in_range;
  logic                  fetch_in_range;

  // Address range checks use one extra bit so DEPTH = 2^ADDR_WIDTH is exact.
  assign load_in_range  = ({1'b0, bus.load_addr}  < DEPTH_X);
  assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_X);

  // Next state and handshake readies; readies depend only on state, valid and inst_ready.
  always_comb begin
    state_d     = state_q;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    if (state_q == S_INIT) begin
      if (clr_cnt == LAST_IDX) begin
        state_d = S_RUN;
      end
    end else begin
      load_ready  = 1'b1;
      fetch_ready = !vld_p1 || bus.inst_ready;
    end
  end

  assign load_acc  = bus.load_en   && load_ready;
  assign fetch_acc = bus.fetch_req && fetch_ready;

  // State register and clear counter; reset restarts the clear sweep from word 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_INIT;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Word array writes: FILL sweep during INIT, in-range loader writes during RUN.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state_q == S_INIT) begin
        mem[clr_cnt] <= FILL_W;
      end else if (load_acc && load_in_range) begin
        mem[bus.load_addr] <= bus.load_data;
      end
    end
  end

  // Stage p1: registered fetch result; NBA ordering gives read-before-write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (fetch_acc) begin
      vld_p1 <= 1'b1;
      if (fetch_in_range) begin
        inst_p1 <= mem[bus.fetch_addr];
        err_p1  <= 1'b0;
      end else begin
        inst_p1 <= '0;
        err_p1  <= 1'b1;
      end
    end else if (vld_p1 && bus.inst_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.fetch_ready = fetch_ready;
  assign bus.inst_valid  = vld_p1;
  assign bus.inst        = inst_p1;
  assign bus.inst_err    = err_p1;

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, loadable instruction memory for the single-cycle and upcoming multi-cycle CPUs. It replaces the hard-wired asynchronous ROM with a synchronous-read word array. Contents are cleared after reset and written through a loader port, so test programs change without re-synthesis. The fetch side uses a request/valid handshake with backpressure and flags fetches to addresses beyond `DEPTH`.

## Interface
- `DATA_WIDTH`, default 32: instruction width in bits.
- `ADDR_WIDTH`, default 5: word-index width of both address ports.
- `DEPTH`, default 20: number of implemented words. Legal range is 1 ≤ `DEPTH` ≤ 2^`ADDR_WIDTH`.
- `FILL`, default 32'h00000000: value written into every word during INIT (a NOP). Truncated to `DATA_WIDTH`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `load_en` in 1: loader write strobe.
- `load_addr` in `ADDR_WIDTH`: loader word index.
- `load_data` in `DATA_WIDTH`: loader write data.
- `load_ready` out 1: high when a load is accepted this cycle.
- `fetch_req` in 1: fetch request.
- `fetch_addr` in `ADDR_WIDTH`: fetch word index (PC[ADDR_WIDTH+1:2]).
- `fetch_ready` out 1: high when a fetch is accepted this cycle.
- `inst_valid` out 1: `inst` / `inst_err` hold a result.
- `inst` out `DATA_WIDTH`: fetched instruction.
- `inst_err` out 1: the result came from an out-of-range address.
- `inst_ready` in 1: the consumer takes the result this cycle.

## Operation
- The FSM has two states, INIT and RUN.
  - `resetn`=0 at an edge forces INIT, `clr_cnt`=0 and `inst_valid`=0. This applies from any state, including mid-INIT and mid-handshake; a pending result is discarded.
  - INIT: each cycle writes `FILL` to word `clr_cnt`, then increments `clr_cnt`. When `clr_cnt`=`DEPTH`-1 is written, the FSM goes to RUN. INIT lasts exactly `DEPTH` cycles.
  - RUN is terminal until the next reset.
- Load: `load_ready` = (state==RUN).
  - A load is accepted when `load_en`·`load_ready`.
  - If `load_addr` < `DEPTH`, the word is written at that edge.
  - If `load_addr` ≥ `DEPTH`, the load is silently dropped (no write, no flag).
  - Loads during INIT are ignored.
- Fetch: `fetch_ready` = (state==RUN)·(!`inst_valid` | `inst_ready`).
  - A fetch is accepted when `fetch_req`·`fetch_ready`.
  - On the accepting edge, the output register captures `mem[fetch_addr]` and `inst_err`=0 if `fetch_addr` < `DEPTH`. Otherwise it captures `inst`=0 and `inst_err`=1. `inst_valid`=1 either way.
- Hold: while `inst_valid`=1 and `inst_ready`=0, `inst`, `inst_err` and `inst_valid` are frozen and no new fetch is accepted.
- Drain: if `inst_valid`·`inst_ready` and no fetch is accepted in that cycle, then `inst_valid`→0 next edge. `inst` and `inst_err` keep their last values.
- Back-to-back: if `inst_valid`·`inst_ready`·`fetch_req` in one cycle, the old result is consumed and the new one loads on the same edge. This gives one instruction per cycle.
- Simultaneous load and fetch to the same in-range word: the fetch returns the OLD contents (read-before-write). A fetch in the next cycle returns the new data.
- Out-of-range never aliases: with `DEPTH`=20, word 20 is flagged, not mapped to word 4.

## Timing
- Reset values:
  - `inst_valid`=0, `inst`=0, `inst_err`=0.
  - `fetch_ready`=0 and `load_ready`=0 (state INIT).
- First edge with `resetn`=1 is cycle 0. Words are cleared on cycles 0…`DEPTH`-1. `fetch_ready` and `load_ready` first go high in cycle `DEPTH`.
- Fetch latency is one cycle: a request accepted at edge N gives `inst_valid`=1 after edge N, visible in cycle N+1.
- Load-to-fetch visibility: a word loaded at edge N is returned by a fetch accepted at edge N+1 or later.
- Throughput: 1 fetch per cycle while `inst_ready`=1, and 1 load per cycle in RUN.
- `fetch_ready` and `load_ready` are combinational from state, `inst_valid` and `inst_ready`. There is no combinational path from `fetch_req` or `fetch_addr` to any output.

## Test plan
- **Reset/INIT:** `DEPTH`=20; `resetn` low 3 cycles, then high. Required: `fetch_ready`=0 for cycles 0–19 and 1 in cycle 20. Fetches of words 0–19 then all return 32'h00000000 with `inst_err`=0.
- **Load then stream:** load the 20-word MIPS test program (word 0=32'h24010001 … word 19=32'h08000000), then issue fetches 0–19 with `inst_ready`=1 throughout. Required: 20 consecutive valid cycles, in order, with exact words.
- **Backpressure:** fetch word 1 (32'h00011100) with `inst_ready`=0 for 4 cycles. Required: `inst` held stable, `fetch_ready`=0, and a competing fetch of word 2 not accepted until the cycle `inst_ready`=1.
- **Out-of-range:** fetch word 20, then word 31. Required: `inst`=0 and `inst_err`=1 for both. A load to word 25 followed by a fetch of word 5 shows word 5 unchanged.
- **Read-during-write:** word 3 holds 32'h00022082; in the same cycle, load 32'hDEADBEEF to word 3 and fetch word 3. Required: 32'h00022082 returned, then 32'hDEADBEEF on the next fetch.
- **Reset mid-operation:** assert `resetn`=0 for 1 cycle while `inst_valid`=1 is held under backpressure. Required: `inst_valid`=0 next cycle, a full 20-cycle INIT, and all words read back as `FILL`.
